// File: rtl/memory_stage.sv
// ============================================================================
// Module  : memory_stage
// Brief   : Y86-64 memory stage with byte-addressed data memory and W register.
//           Optional macro MEMORY_STAGE_ALIGN_CHECK_EN flags unaligned accesses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [63:0] M_valP,
    input  logic [63:0] M_valB,
    input  logic [63:0] M_valC,
    input  logic [3:0]  M_rA,
    input  logic [3:0]  M_rB,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [2:0]  m_stat,
    output logic [63:0] m_valM,
    output logic [3:0]  m_dstE,
    output logic [3:0]  m_dstM,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

    logic [7:0]    mem_q [0:MEM_BYTES-1];

    logic          is_read;
    logic          is_write;
    logic          adr_err;
    logic          mem_we;
    logic [63:0]   addr;
    logic [63:0]   wdata;
    logic [AW-1:0] idx;

    logic [2:0]  W_stat_q,  W_stat_d;
    logic [3:0]  W_icode_q, W_icode_d;
    logic [63:0] W_valE_q,  W_valE_d;
    logic [63:0] W_valM_q,  W_valM_d;
    logic [3:0]  W_dstE_q,  W_dstE_d;
    logic [3:0]  W_dstM_q,  W_dstM_d;

    logic unused_ok;
    assign unused_ok = ^{M_valB, M_valC};

    assign is_read  = (M_icode == I_MRMOV) || (M_icode == I_POP) || (M_icode == I_RET);
    assign is_write = (M_icode == I_RMMOV) || (M_icode == I_PUSH) || (M_icode == I_CALL);
    assign addr     = ((M_icode == I_POP) || (M_icode == I_RET)) ? M_valA : M_valE;
    assign wdata    = (M_icode == I_CALL) ? M_valP : M_valA;
    assign idx      = addr[AW-1:0];

`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
    assign adr_err = (is_read || is_write) && ((addr > LAST_ADDR) || (addr[2:0] != 3'd0));
`else
    assign adr_err = (is_read || is_write) && (addr > LAST_ADDR);
`endif

    // Any faulting instruction already in W blocks later stores from committing.
    assign mem_we = is_write && !adr_err && (M_stat == S_AOK) && !reset &&
                    (W_stat_q != S_HLT) && (W_stat_q != S_ADR) && (W_stat_q != S_INS);

    assign m_stat = adr_err ? S_ADR : M_stat;

    always_comb begin
        m_valM = '0;
        if (is_read && !adr_err) begin
            for (int k = 0; k < 8; k++) begin
                m_valM[8*k +: 8] = mem_q[idx + AW'(k)];
            end
        end
    end

    always_comb begin
        m_dstE = R_NONE;
        case (M_icode)
            I_IRMOV, I_OP:                 m_dstE = M_rB;
            I_CMOV:                        m_dstE = M_Cnd ? M_rB : R_NONE;
            I_PUSH, I_POP, I_CALL, I_RET:  m_dstE = R_RSP;
            default:                       m_dstE = R_NONE;
        endcase
    end

    assign m_dstM = ((M_icode == I_MRMOV) || (M_icode == I_POP)) ? M_rA : R_NONE;

    // Memory has no reset so its contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[idx + AW'(k)] <= wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        W_stat_d  = W_stat_q;
        W_icode_d = W_icode_q;
        W_valE_d  = W_valE_q;
        W_valM_d  = W_valM_q;
        W_dstE_d  = W_dstE_q;
        W_dstM_d  = W_dstM_q;
        if (reset || (!W_stall && W_bubble)) begin
            W_stat_d  = S_AOK;
            W_icode_d = I_NOP;
            W_valE_d  = '0;
            W_valM_d  = '0;
            W_dstE_d  = R_NONE;
            W_dstM_d  = R_NONE;
        end else if (!W_stall) begin
            W_stat_d  = m_stat;
            W_icode_d = M_icode;
            W_valE_d  = M_valE;
            W_valM_d  = m_valM;
            W_dstE_d  = m_dstE;
            W_dstM_d  = m_dstM;
        end
    end

    always_ff @(posedge clk) begin
        W_stat_q  <= W_stat_d;
        W_icode_q <= W_icode_d;
        W_valE_q  <= W_valE_d;
        W_valM_q  <= W_valM_d;
        W_dstE_q  <= W_dstE_d;
        W_dstM_q  <= W_dstM_d;
    end

    assign W_stat  = W_stat_q;
    assign W_icode = W_icode_q;
    assign W_valE  = W_valE_q;
    assign W_valM  = W_valM_q;
    assign W_dstE  = W_dstE_q;
    assign W_dstM  = W_dstM_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// Module  : tb_memory_stage
// Brief   : Directed table-driven bench for memory_stage (MEM_BYTES = 1024).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA, M_valP, M_valB, M_valC;
    logic [3:0]  M_rA, M_rB;
    logic        W_stall, W_bubble;
    logic [2:0]  m_stat;
    logic [63:0] m_valM;
    logic [3:0]  m_dstE, m_dstM;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    memory_stage #(.MEM_BYTES(1024)) dut (
        .clk(clk), .reset(reset),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_valP(M_valP),
        .M_valB(M_valB), .M_valC(M_valC), .M_rA(M_rA), .M_rB(M_rB),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .m_stat(m_stat), .m_valM(m_valM), .m_dstE(m_dstE), .m_dstM(m_dstM),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [63:0] valP;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [2:0]  e_stat;
        logic [63:0] e_valM;
        logic [3:0]  e_dstE;
        logic [3:0]  e_dstM;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic [3:0] icode, logic [2:0] stat, logic cnd,
                                logic [63:0] valE, logic [63:0] valA, logic [63:0] valP,
                                logic [3:0] rA, logic [3:0] rB, logic [2:0] e_stat,
                                logic [63:0] e_valM, logic [3:0] e_dstE, logic [3:0] e_dstM);
        vec_t v;
        v.icode = icode; v.stat = stat; v.cnd = cnd;
        v.valE = valE; v.valA = valA; v.valP = valP; v.rA = rA; v.rB = rB;
        v.e_stat = e_stat; v.e_valM = e_valM; v.e_dstE = e_dstE; v.e_dstM = e_dstM;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        M_icode = v.icode; M_stat = v.stat; M_Cnd = v.cnd;
        M_valE = v.valE; M_valA = v.valA; M_valP = v.valP;
        M_rA = v.rA; M_rB = v.rB;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] icode, input logic [63:0] valE, input logic [63:0] valA);
        drive(mk(icode, 3'd1, 1'b0, valE, valA, 64'd0, 4'h1, 4'h6, 3'd0, 64'd0, 4'h0, 4'h0));
    endtask

    initial begin
        logic [2:0]  unal_stat;
        logic [63:0] unal_valM;
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
        unal_stat = 3'd3;
        unal_valM = 64'd0;
`else
        unal_stat = 3'd1;
        unal_valM = 64'hA5A6A71122334455;
`endif
        //       icode stat cnd valE                    valA                   valP    rA    rB    e_stat e_valM                  dstE  dstM
        tv.push_back(mk(4'h4, 3'd1, 0, 64'h10,  64'h1122334455667788, 64'h0,  4'h3, 4'hF, 3'd1, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h4, 3'd1, 0, 64'h18,  64'hA0A1A2A3A4A5A6A7, 64'h0,  4'h3, 4'hF, 3'd1, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h4, 3'd1, 0, 64'h20,  64'h0F0E0D0C0B0A0908, 64'h0,  4'h3, 4'hF, 3'd1, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h5, 3'd1, 0, 64'h10,  64'h0, 64'h0, 4'h3, 4'hF, 3'd1, 64'h1122334455667788, 4'hF, 4'h3));
        tv.push_back(mk(4'h5, 3'd1, 0, 64'h13,  64'h0, 64'h0, 4'h1, 4'hF, unal_stat, unal_valM, 4'hF, 4'h1));
        tv.push_back(mk(4'hB, 3'd1, 0, 64'h18,  64'h10, 64'h0, 4'h2, 4'hF, 3'd1, 64'h1122334455667788, 4'h4, 4'h2));
        tv.push_back(mk(4'h9, 3'd1, 0, 64'h20,  64'h18, 64'h0, 4'hF, 4'hF, 3'd1, 64'hA0A1A2A3A4A5A6A7, 4'h4, 4'hF));
        tv.push_back(mk(4'h6, 3'd1, 0, 64'h5,   64'h0, 64'h0, 4'h1, 4'h6, 3'd1, 64'h0, 4'h6, 4'hF));
        tv.push_back(mk(4'h3, 3'd1, 0, 64'h7,   64'h0, 64'h0, 4'hF, 4'h7, 3'd1, 64'h0, 4'h7, 4'hF));
        tv.push_back(mk(4'h2, 3'd1, 0, 64'h8,   64'h0, 64'h0, 4'h1, 4'h5, 3'd1, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h2, 3'd1, 1, 64'h8,   64'h0, 64'h0, 4'h1, 4'h5, 3'd1, 64'h0, 4'h5, 4'hF));
        tv.push_back(mk(4'h1, 3'd1, 0, 64'h0,   64'h0, 64'h0, 4'h1, 4'h2, 3'd1, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h7, 3'd1, 0, 64'h0,   64'h0, 64'h0, 4'h1, 4'h2, 3'd1, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h0, 3'd2, 0, 64'h0,   64'h0, 64'h0, 4'h1, 4'h2, 3'd2, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h1, 3'd1, 0, 64'h0,   64'h0, 64'h0, 4'h1, 4'h2, 3'd1, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h8, 3'd1, 0, 64'h100, 64'h999, 64'h40, 4'hF, 4'hF, 3'd1, 64'h0, 4'h4, 4'hF));
        tv.push_back(mk(4'h5, 3'd1, 0, 64'h100, 64'h0, 64'h0, 4'h0, 4'hF, 3'd1, 64'h40, 4'hF, 4'h0));
        tv.push_back(mk(4'hA, 3'd1, 0, 64'h200, 64'hDEADBEEFCAFEF00D, 64'h0, 4'h1, 4'hF, 3'd1, 64'h0, 4'h4, 4'hF));
        tv.push_back(mk(4'hB, 3'd1, 0, 64'h208, 64'h200, 64'h0, 4'h9, 4'hF, 3'd1, 64'hDEADBEEFCAFEF00D, 4'h4, 4'h9));
        tv.push_back(mk(4'h4, 3'd1, 0, 64'h3F8, 64'h0102030405060708, 64'h0, 4'h1, 4'hF, 3'd1, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h5, 3'd1, 0, 64'h3F8, 64'h0, 64'h0, 4'h8, 4'hF, 3'd1, 64'h0102030405060708, 4'hF, 4'h8));
        tv.push_back(mk(4'hA, 3'd1, 0, 64'h3F9, 64'hFFFFFFFFFFFFFFFF, 64'h0, 4'h1, 4'hF, 3'd3, 64'h0, 4'h4, 4'hF));
        tv.push_back(mk(4'h4, 3'd1, 0, 64'h20,  64'h5555555555555555, 64'h0, 4'h1, 4'hF, 3'd1, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h4, 3'd2, 0, 64'h20,  64'h6666666666666666, 64'h0, 4'h1, 4'hF, 3'd2, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h1, 3'd1, 0, 64'h0,   64'h0, 64'h0, 4'h1, 4'h2, 3'd1, 64'h0, 4'hF, 4'hF));
        tv.push_back(mk(4'h5, 3'd1, 0, 64'h3F8, 64'h0, 64'h0, 4'h8, 4'hF, 3'd1, 64'h0102030405060708, 4'hF, 4'h8));
        tv.push_back(mk(4'h5, 3'd1, 0, 64'h20,  64'h0, 64'h0, 4'h8, 4'hF, 3'd1, 64'h0F0E0D0C0B0A0908, 4'hF, 4'h8));
        tv.push_back(mk(4'h5, 3'd1, 0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 4'h1, 4'hF, 3'd3, 64'h0, 4'hF, 4'h1));
        tv.push_back(mk(4'h1, 3'd1, 0, 64'h0,   64'h0, 64'h0, 4'h1, 4'h2, 3'd1, 64'h0, 4'hF, 4'hF));

        reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
        M_valB = 64'h0; M_valC = 64'h0;
        drive_op(4'h1, 64'h0, 64'h0);
        step(); step();
        chk("rst W_stat",  64'(W_stat),  64'd1);
        chk("rst W_icode", 64'(W_icode), 64'd1);
        chk("rst W_valE",  W_valE,       64'd0);
        chk("rst W_valM",  W_valM,       64'd0);
        chk("rst W_dstE",  64'(W_dstE),  64'hF);
        chk("rst W_dstM",  64'(W_dstM),  64'hF);
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            #4;
            chk($sformatf("v%0d m_stat", i), 64'(m_stat), 64'(tv[i].e_stat));
            chk($sformatf("v%0d m_valM", i), m_valM,      tv[i].e_valM);
            chk($sformatf("v%0d m_dstE", i), 64'(m_dstE), 64'(tv[i].e_dstE));
            chk($sformatf("v%0d m_dstM", i), 64'(m_dstM), 64'(tv[i].e_dstM));
            step();
            chk($sformatf("v%0d W_stat", i),  64'(W_stat),  64'(tv[i].e_stat));
            chk($sformatf("v%0d W_icode", i), 64'(W_icode), 64'(tv[i].icode));
            chk($sformatf("v%0d W_valE", i),  W_valE,       tv[i].valE);
            chk($sformatf("v%0d W_valM", i),  W_valM,       tv[i].e_valM);
            chk($sformatf("v%0d W_dstE", i),  64'(W_dstE),  64'(tv[i].e_dstE));
            chk($sformatf("v%0d W_dstM", i),  64'(W_dstM),  64'(tv[i].e_dstM));
        end

        // Stall beats bubble; the store issued during the stall still commits.
        drive_op(4'h6, 64'h99, 64'h0);
        step();
        chk("pre-stall W_icode", 64'(W_icode), 64'd6);
        drive_op(4'h4, 64'h30, 64'h3030303030303030);
        W_stall = 1'b1; W_bubble = 1'b1;
        step();
        chk("stall W_icode", 64'(W_icode), 64'd6);
        chk("stall W_valE",  W_valE,       64'h99);
        chk("stall W_dstE",  64'(W_dstE),  64'd6);
        W_stall = 1'b0;
        drive_op(4'h3, 64'h55, 64'h0);
        step();
        chk("bubble W_icode", 64'(W_icode), 64'd1);
        chk("bubble W_stat",  64'(W_stat),  64'd1);
        chk("bubble W_valE",  W_valE,       64'd0);
        chk("bubble W_dstE",  64'(W_dstE),  64'hF);
        chk("bubble W_dstM",  64'(W_dstM),  64'hF);
        W_bubble = 1'b0;
        drive_op(4'h5, 64'h30, 64'h0);
        #4;
        chk("store under stall", m_valM, 64'h3030303030303030);
        step();

        // Reset in the same cycle as a store discards the store.
        drive_op(4'h4, 64'h30, 64'hBADBADBADBADBAD0);
        reset = 1'b1;
        step();
        chk("midrst W_icode", 64'(W_icode), 64'd1);
        chk("midrst W_stat",  64'(W_stat),  64'd1);
        chk("midrst W_dstE",  64'(W_dstE),  64'hF);
        reset = 1'b0;
        drive_op(4'h5, 64'h30, 64'h0);
        #4;
        chk("midrst store dropped", m_valM, 64'h3030303030303030);
        step();
        drive_op(4'h5, 64'h10, 64'h0);
        #4;
        chk("mem kept over reset", m_valM, 64'h1122334455667788);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter MEM_BYTES, default 1024, data-memory size in bytes; SHALL be at least 8.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 M_stat in 3, M_icode in 4, M_Cnd in 1: M-register status, opcode and condition flag.
REQ-005 M_valE, M_valA, M_valP, M_valB, M_valC in 64, M_rA, M_rB in 4: M-register data and register IDs; M_valB and M_valC are accepted and unused.
REQ-006 W_stall  in  1  holds the W register; W_bubble  in  1  loads a bubble into the W register.
REQ-007 m_stat out 3, m_valM out 64, m_dstE out 4, m_dstM out 4: combinational memory-stage results for forwarding and hazard control.
REQ-008 W_stat out 3, W_icode out 4, W_valE out 64, W_valM out 64, W_dstE out 4, W_dstM out 4: registered writeback state.

Function
REQ-009 Encodings SHALL be as follows.
- Stat: AOK=1, HLT=2, ADR=3, INS=4.
- Icode: HALT 0, NOP 1, CMOV 2, IRMOV 3, RMMOV 4, MRMOV 5, OP 6, JXX 7, CALL 8, RET 9, PUSH A, POP B.
- RSP=4; RNONE=F.
REQ-010 The memory address SHALL be M_valE for RMMOV, PUSH, CALL and MRMOV, and M_valA for POP and RET.
REQ-011 Reads (MRMOV, POP, RET) SHALL return m_valM combinationally as 8 bytes, little-endian, starting at the address; m_valM SHALL be 0 for non-read icodes.
REQ-012 Write data SHALL be M_valA for RMMOV and PUSH, and M_valP for CALL; the write SHALL be 8 bytes, little-endian, committed at the rising edge.
REQ-013 Address error: for any read or write icode with a 64-bit address greater than MEM_BYTES-8, the access SHALL be flagged; compare at full width with no wrap, so 0xFFFF_FFFF_FFFF_FFF8 is an error.
REQ-014 m_stat SHALL be ADR on an address error, otherwise M_stat.
REQ-015 Writes SHALL be suppressed when any of these holds: address error, M_stat≠AOK, W_stat∈{HLT,ADR,INS}, or reset=1.
REQ-016 m_dstE SHALL be:
- M_rB for IRMOV and OP;
- M_rB for CMOV when M_Cnd=1;
- RSP for PUSH, POP, CALL and RET;
- otherwise RNONE.
REQ-017 m_dstM SHALL be M_rA for MRMOV and POP, otherwise RNONE.
REQ-018 W register update, in priority order reset > W_stall > W_bubble > normal:
- stall holds all W_* outputs;
- bubble loads stat AOK, icode NOP, valE/valM 0, dstE/dstM RNONE;
- normal loads m_stat, M_icode, M_valE, m_valM, m_dstE, m_dstM.
REQ-019 Latency SHALL be 0 cycles from M inputs to m_* outputs and 1 cycle to W_*.
REQ-020 A read of an address written in the same cycle SHALL return the old contents; the new data SHALL be visible from the next cycle.
REQ-021 W_stall SHALL NOT suppress a memory write; stalling M is the upstream controller's responsibility.

Reset
REQ-022 While reset=1 at a rising edge, the W register SHALL load the bubble values of REQ-018.
REQ-023 Memory contents SHALL NOT be altered by reset.
REQ-024 Asserting reset mid-stream SHALL discard any pending write in that cycle.

Configuration
REQ-025 Macro MEMORY_STAGE_ALIGN_CHECK_EN.
- Defined: a read or write whose address[2:0]≠0 SHALL also be flagged as an address error (m_stat=ADR, write suppressed).
- Undefined: unaligned accesses SHALL be legal and byte-exact.

Verification
REQ-026 RMMOV, M_valE=0x10, M_valA=0x1122334455667788, AOK; next cycle MRMOV at 0x10, M_rA=3 -> m_valM=0x1122334455667788, byte 0x10=0x88, then W_valM equals it and W_dstM=3.
REQ-027 PUSH, M_valE=MEM_BYTES-7 -> m_stat=ADR, memory unchanged, W_stat=ADR next cycle; a following RMMOV at 0x20 is suppressed because W_stat=ADR.
REQ-028 CMOV, M_rB=5: M_Cnd=0 -> m_dstE=F; M_Cnd=1 -> m_dstE=5; CALL, M_valP=0x40 at 0x100 -> memory 0x100..0x107 = 0x40, m_dstE=4.
REQ-029 W_stall=1 and W_bubble=1 together -> W_* held; W_bubble alone -> W_icode=1, W_stat=1, W_dstE=W_dstM=F.
REQ-030 Reset asserted in the same cycle as RMMOV at 0x30 -> no write to 0x30, W in bubble state; memory written before reset is intact afterwards.
REQ-031 With MEMORY_STAGE_ALIGN_CHECK_EN defined, MRMOV at 0x13 -> m_stat=ADR; undefined -> m_stat=AOK and the value is read byte-exact.
